// File: rtl/rst_seq_pkg.sv
// Shared state codes and sizing helpers for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WLOCK = 2'd0,
    HOLD  = 2'd1,
    REL   = 2'd2,
    RUN   = 2'd3
  } seq_state_e;

  // Smallest r such that 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Lock/request inputs and staged reset outputs of the sequencer.
interface rst_seq_if #(
  parameter int unsigned NSTG = 4
);
  logic            pll_lock;
  logic            sw_rst;
  logic [NSTG-1:0] orst;
  logic            rst_done;
  logic [1:0]      seq_st;

  // Environment side: drives lock and software reset request.
  modport master (
    output pll_lock,
    output sw_rst,
    input  orst,
    input  rst_done,
    input  seq_st
  );

  // Sequencer side.
  modport slave (
    input  pll_lock,
    input  sw_rst,
    output orst,
    output rst_done,
    output seq_st
  );
endinterface

// File: rtl/rst_seq_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
  input  logic clk,
  input  logic irst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  // Both stages clear on reset so lock history starts from zero.
  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: qualify lock, hold, then release stages low to high.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NSTG    = 4,
  parameter int unsigned LOCKFLT = 4,
  parameter int unsigned HOLDCYC = 16,
  parameter int unsigned GAPCYC  = 8
) (
  input  logic        clk,
  input  logic        irst,
  rst_seq_if.slave    bus
);

  localparam int unsigned CNTMAX = max3(LOCKFLT, HOLDCYC, GAPCYC);
  localparam int unsigned CW     = clog2(CNTMAX + 1);
  localparam int unsigned IW     = (clog2(NSTG) < 1) ? 1 : clog2(NSTG);

  localparam logic [CW-1:0] LOCK_TC = CW'(LOCKFLT - 1);
  localparam logic [CW-1:0] HOLD_TC = CW'(HOLDCYC - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'(GAPCYC - 1);
  localparam logic [IW-1:0] LAST_IX = IW'(NSTG - 1);

  logic lock_s;

  seq_state_e      st_q,   st_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic [IW-1:0]   idx_q,  idx_d;
  logic [NSTG-1:0] orst_q, orst_d;
  logic            done_q, done_d;
  logic            abort_c;

  lock_sync u_lock_sync (
    .clk  (clk),
    .irst (irst),
    .d    (bus.pll_lock),
    .q    (lock_s)
  );

  // State, shared counter, stage index and output registers.
  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      st_q   <= WLOCK;
      cnt_q  <= '0;
      idx_q  <= '0;
      orst_q <= '1;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      orst_q <= orst_d;
      done_q <= done_d;
    end
  end

  // Next-state logic; abort overrides any terminal count on the same edge.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    orst_d  = orst_q;
    done_d  = done_q;
    abort_c = (st_q != WLOCK) && (!lock_s || bus.sw_rst);

    if (abort_c) begin
      st_d   = WLOCK;
      cnt_d  = '0;
      idx_d  = '0;
      orst_d = '1;
      done_d = 1'b0;
    end else begin
      case (st_q)
        WLOCK: begin
          if (!lock_s || bus.sw_rst) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_TC) begin
            st_d  = HOLD;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_TC) begin
            cnt_d     = '0;
            orst_d[0] = 1'b0;
            if (NSTG == 1) begin
              st_d   = RUN;
              done_d = 1'b1;
            end else begin
              st_d  = REL;
              idx_d = IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        REL: begin
          if (cnt_q == GAP_TC) begin
            cnt_d  = '0;
            orst_d = orst_q & ~(NSTG'(1) << idx_q);
            if (idx_q == LAST_IX) begin
              st_d   = RUN;
              done_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          st_d = RUN;
        end
        default: begin
          st_d   = WLOCK;
          cnt_d  = '0;
          idx_d  = '0;
          orst_d = '1;
          done_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.orst     = orst_q;
  assign bus.rst_done = done_q;
  assign bus.seq_st   = st_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed scoreboard bench for the staged reset sequencer.
module tb_rst_seq;

  logic clk;
  logic irst;
  int   edge_n;

  rst_seq_if #(.NSTG(4)) b4 ();
  rst_seq_if #(.NSTG(1)) b1 ();

  rst_seq #(.NSTG(4), .LOCKFLT(4), .HOLDCYC(16), .GAPCYC(8)) dut4 (
    .clk  (clk),
    .irst (irst),
    .bus  (b4)
  );

  rst_seq #(.NSTG(1), .LOCKFLT(1), .HOLDCYC(1), .GAPCYC(8)) dut1 (
    .clk  (clk),
    .irst (irst),
    .bus  (b1)
  );

  typedef struct {
    int         e;
    logic [3:0] orst;
    logic       done;
    logic [1:0] st;
  } ev_t;

  ev_t  q4[$];
  ev_t  q1[$];
  logic [3:0] prev4;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge number relative to the first edge after reset release.
  always @(posedge clk or posedge irst) begin
    if (irst) edge_n <= 0;
    else      edge_n <= edge_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic push4(input int e, input logic [3:0] o, input logic d, input logic [1:0] s);
    ev_t ev;
    ev.e = e; ev.orst = o; ev.done = d; ev.st = s;
    q4.push_back(ev);
  endtask

  task automatic push1(input int e, input logic o, input logic d, input logic [1:0] s);
    ev_t ev;
    ev.e = e; ev.orst = {3'b000, o}; ev.done = d; ev.st = s;
    q1.push_back(ev);
  endtask

  // Compare scheduled events and flag any unscheduled orst movement.
  task automatic check_cycle();
    ev_t ev;
    bit  hit;
    hit = 1'b0;
    while (q4.size() > 0 && q4[0].e == edge_n) begin
      ev = q4.pop_front();
      chk("orst4", 32'(b4.orst), 32'(ev.orst));
      chk("done4", 32'(b4.rst_done), 32'(ev.done));
      chk("st4", 32'(b4.seq_st), 32'(ev.st));
      hit = 1'b1;
    end
    if (q4.size() > 0 && q4[0].e < edge_n) begin
      ev = q4.pop_front();
      chk("missed_event4", 32'(edge_n), 32'(ev.e));
    end
    if (!hit) chk("orst4_stable", 32'(b4.orst), 32'(prev4));
    prev4 = b4.orst;
    while (q1.size() > 0 && q1[0].e == edge_n) begin
      ev = q1.pop_front();
      chk("orst1", 32'(b1.orst), 32'(ev.orst[0]));
      chk("done1", 32'(b1.rst_done), 32'(ev.done));
      chk("st1", 32'(b1.seq_st), 32'(ev.st));
    end
    chk("nstg1_no_rel", 32'(b1.seq_st == 2'd2), 32'(0));
  endtask

  task automatic run_until(input int e);
    int guard;
    guard = 0;
    while (edge_n < e) begin
      @(posedge clk);
      #1;
      check_cycle();
      guard++;
      if (guard > 2000) begin
        chk("run_timeout", 32'(edge_n), 32'(e));
        break;
      end
    end
  endtask

  task automatic drain();
    chk("queue4_empty", 32'(q4.size()), 32'(0));
    chk("queue1_empty", 32'(q1.size()), 32'(0));
    q4.delete();
    q1.delete();
  endtask

  // Assert reset off-edge, check reset values, release on a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    irst = 1'b1;
    #1;
    chk("rst_orst4", 32'(b4.orst), 32'hf);
    chk("rst_done4", 32'(b4.rst_done), 32'(0));
    chk("rst_st4", 32'(b4.seq_st), 32'(0));
    chk("rst_orst1", 32'(b1.orst), 32'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    irst = 1'b0;
    prev4 = b4.orst;
  endtask

  task automatic push_nominal(input int base);
    push4(base,      4'b1110, 1'b0, 2'd2);
    push4(base + 8,  4'b1100, 1'b0, 2'd2);
    push4(base + 16, 4'b1000, 1'b0, 2'd2);
    push4(base + 24, 4'b0000, 1'b1, 2'd3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    irst = 1'b1;
    b4.pll_lock = 1'b1;
    b4.sw_rst   = 1'b0;
    b1.pll_lock = 1'b1;
    b1.sw_rst   = 1'b0;
    prev4 = 4'hf;

    // Nominal release, then lock loss in RUN and recovery.
    do_reset();
    push1(3, 1'b1, 1'b0, 2'd1);
    push1(4, 1'b0, 1'b1, 2'd3);
    push4(6, 4'b1111, 1'b0, 2'd1);
    push_nominal(22);
    push4(63, 4'b1111, 1'b0, 2'd0);
    push4(76, 4'b1111, 1'b0, 2'd1);
    push_nominal(92);
    run_until(60);
    b4.pll_lock = 1'b0;
    run_until(70);
    b4.pll_lock = 1'b1;
    run_until(120);
    drain();

    // Single-cycle lock glitch while filtering.
    do_reset();
    push4(9, 4'b1111, 1'b0, 2'd1);
    push_nominal(25);
    run_until(2);
    b4.pll_lock = 1'b0;
    run_until(3);
    b4.pll_lock = 1'b1;
    run_until(55);
    chk("glitch_final_st", 32'(b4.seq_st), 32'(3));
    q1.delete();
    drain();

    // Software reset pulse mid-release.
    do_reset();
    push4(22, 4'b1110, 1'b0, 2'd2);
    push4(30, 4'b1100, 1'b0, 2'd2);
    push4(34, 4'b1111, 1'b0, 2'd0);
    push4(38, 4'b1111, 1'b0, 2'd1);
    push_nominal(54);
    run_until(33);
    chk("pre_swrst_orst", 32'(b4.orst), 32'hc);
    b4.sw_rst = 1'b1;
    run_until(34);
    b4.sw_rst = 1'b0;
    run_until(85);
    drain();

    // Asynchronous reset mid-hold, then a clean restart.
    do_reset();
    run_until(10);
    chk("hold_before_irst", 32'(b4.seq_st), 32'(1));
    #2;
    irst = 1'b1;
    #1;
    chk("async_orst4", 32'(b4.orst), 32'hf);
    chk("async_st4", 32'(b4.seq_st), 32'(0));
    chk("async_done4", 32'(b4.rst_done), 32'(0));
    @(negedge clk);
    @(negedge clk);
    irst = 1'b0;
    prev4 = b4.orst;
    push4(6, 4'b1111, 1'b0, 2'd1);
    push_nominal(22);
    run_until(50);
    q1.delete();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Staged reset sequencer that sits directly downstream of the asynchronous-assert/synchronous-deassert reset synchronizer. It holds all functional resets asserted until the PLL lock is stable and a minimum hold time has elapsed. It then releases NSTG reset domains one at a time, in a fixed order and with a fixed gap. Lock loss or a software reset request re-asserts every stage and restarts the sequence.

## Interface
- NSTG, 4, number of staged reset outputs; legal range 1..8.
- LOCKFLT, 4, consecutive cycles synchronized lock must be high before hold starts; ≥1.
- HOLDCYC, 16, cycles all stages stay asserted after lock is qualified; ≥1.
- GAPCYC, 8, cycles between successive stage releases; ≥1.
- clk  in  1  sequencer clock.
- irst  in  1  reset, asynchronous, active-high; clock clk.
- pll_lock  in  1  PLL lock, asynchronous to clk; double-flop synchronized internally.
- sw_rst  in  1  software reset request, clk domain, sampled every cycle; any high cycle counts.
- orst  out  NSTG  active-high staged resets; bit 0 is released first.
- rst_done  out  1  high when all stages are released.
- seq_st  out  2  state code: 0 WLOCK, 1 HOLD, 2 REL, 3 RUN.

## Operation
- All outputs are registered. Reset values: orst all ones, rst_done 0, seq_st WLOCK, counters 0, stage index 0, lock synchronizer flops 0.
- Counter width is clog2(max(LOCKFLT,HOLDCYC,GAPCYC)+1). Stage index width is clog2(NSTG), minimum 1.
- WLOCK:
  - Filter counter increments each cycle lock_s (synchronized lock) is high and clears on any low cycle.
  - When the count reaches LOCKFLT, go to HOLD and clear the counter.
- HOLD: count HOLDCYC cycles. On terminal count, go to REL, deassert orst[0], set stage index to 1, clear the counter.
- REL: count GAPCYC cycles. On terminal count, deassert orst[index] and increment the index.
  - On the edge orst[NSTG-1] deasserts, go to RUN and set rst_done 1 on that same edge.
  - NSTG=1: orst[0] deasserts on the HOLD→RUN edge; REL is skipped.
- RUN: steady state. Released stages never re-assert spontaneously.
- Abort applies in any state except WLOCK. Condition: lock_s low or sw_rst high.
  - Next edge: orst all ones, rst_done 0, go to WLOCK, counters and index cleared.
- In WLOCK, sw_rst high also clears the filter counter.
- Priority: irst > abort > normal progression.
- Simultaneous terminal count and abort: abort wins; no stage is released on that edge.
- Released bits form a contiguous low-order run. orst is always monotonic: orst[k]=0 implies orst[j]=0 for all j<k.

## Timing
- Edge 1 is the first rising clk edge with irst low. pll_lock is high and stable throughout.
- lock_s is high after edge 2.
- HOLD entered at edge 2+LOCKFLT.
- orst[0] falls at edge 2+LOCKFLT+HOLDCYC.
- orst[k] falls at edge 2+LOCKFLT+HOLDCYC+k·GAPCYC.
- Defaults: orst falls at edges 22, 30, 38, 46; rst_done rises at edge 46.
- Abort latency:
  - sw_rst: 1 edge.
  - pll_lock falling: 3 edges (2 synchronizer + 1 register).
- irst assertion forces reset values asynchronously, including mid-sequence. Deassertion restarts from WLOCK with zero history.

## Structure
- Package/include rst_seq_pkg: state codes (WLOCK=0, HOLD=1, REL=2, RUN=3) and the clog2 helper function.
- Sub-module lock_sync: 2-flop synchronizer for pll_lock, reset to 0 by irst, both flops marked ASYNC_REG.
- Remaining logic (FSM, single shared counter, stage index, output register) lives in rst_seq.

## Test plan
- Defaults, lock high from reset → orst falls at edges 22/30/38/46 in order, rst_done rises at 46, seq_st ends at 3.
- Lock glitch low for 1 cycle at edge 4 in WLOCK → filter restarts; orst[0] falls 3 edges later than nominal, at 25.
- sw_rst pulse at edge 33, in REL with orst=4'b1100 → orst=4'b1111, rst_done 0, seq_st 0 at edge 34; sequence re-releases orst[0] 20 edges after re-entry.
- pll_lock dropped in RUN at edge 60 → orst all ones at edge 63; lock restored at 70 → full sequence repeats with the same gaps.
- irst asserted mid-HOLD, asynchronous to clk → orst all ones immediately, before the next edge; after release the timing matches scenario 1.
- NSTG=1, HOLDCYC=1, LOCKFLT=1 → orst[0] and rst_done change at edge 4; REL never observed on seq_st.
